// File: rtl/trig_pkg.sv
// Shared types and defaults for the trigger conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the parameter defaults and the idle level of
// the external trigger line. The line idles high, so every synchronizer and
// filter flop resets to that level.
package trig_pkg;

    localparam int   SYNC_STAGES_DEF = 2;
    localparam int   CNT_W_DEF       = 16;
    localparam logic TRIG_RST_LVL    = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        GAP     = 2'd2,
        HOLDOFF = 2'd3
    } trig_state_t;

endpackage

// File: rtl/trig_glitch_filter.sv
// Synchronizes the async trigger line, glitch-filters it and flags falling edges.
// Latency: trig_in fall to fall high = SYNC_STAGES + filter_len + 1 clocks.
// Backpressure: none; fall is a one-clock flag that is not held.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   trig_in      - asynchronous external trigger, idle high
//   filter_len   - filter length; the synchronized level must differ from the
//                  filtered level for filter_len+1 consecutive clocks to pass
//   fall         - one-clock flag: filtered level went 1 -> 0
module trig_glitch_filter
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig_in,
    input  logic [3:0] filter_len,
    output logic       fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Tracks which synchronizer stages hold a real sample rather than the reset preset.
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   trig_s;
    logic                   trig_f;
    logic                   trig_f_prev;
    logic [3:0]             flt_cnt;
    // Edges are only honoured once the real line has been seen high after reset;
    // a line already low at reset release is not a new event.
    logic                   edge_en;

    assign trig_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{TRIG_RST_LVL}};
            sync_vld_q  <= '0;
            trig_f      <= TRIG_RST_LVL;
            trig_f_prev <= TRIG_RST_LVL;
            flt_cnt     <= '0;
            edge_en     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], trig_in};
            sync_vld_q  <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            edge_en     <= edge_en | (sync_vld_q[SYNC_STAGES-1] & trig_s);
            trig_f_prev <= trig_f;
            if (trig_s != trig_f) begin
                // >= keeps the filter safe if filter_len shrinks mid-count.
                if (flt_cnt >= filter_len) begin
                    trig_f  <= trig_s;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 4'd1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall = edge_en & trig_f_prev & ~trig_f;

endmodule

// File: rtl/trigger_conditioner.sv
// Turns filtered falling edges of an external trigger into start pulses, with burst and holdoff.
// Latency: trig_in fall to trigger high = SYNC_STAGES + filter_len + 2 clocks for a clean edge.
// Backpressure: none; edges arriving while busy are dropped and flagged on missed.
//
// Build option: define TRIG_BURST_EN to enable the GAP state and burst pulses;
// without it burst_num/burst_period are ignored and each edge yields one pulse.
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   trig_in        - asynchronous external trigger, active on its falling edge
//   arm            - 1 accepts edges; 0 ignores edges and returns to IDLE
//   filter_len     - glitch filter length in clocks
//   holdoff        - dead time after the last pulse of a sequence
//   burst_num      - extra pulses per accepted edge
//   burst_period   - spacing between burst pulses (0 treated as 1)
//   clr_status     - one-cycle clear of missed and trig_count
//   trigger        - one-clock start pulse
//   busy           - FSM not in IDLE
//   missed         - sticky: an edge arrived while busy
//   trig_count     - saturating count of emitted pulses
module trigger_conditioner
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic [3:0]       filter_len,
    input  logic [15:0]      holdoff,
    input  logic [7:0]       burst_num,
    input  logic [15:0]      burst_period,
    input  logic             clr_status,
    output logic             trigger,
    output logic             busy,
    output logic             missed,
    output logic [CNT_W-1:0] trig_count
);

    logic        fall;
    trig_state_t state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] hold_q, hold_d;

    trig_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .filter_len (filter_len),
        .fall       (fall)
    );

`ifdef TRIG_BURST_EN
    logic [7:0]  rem_q, rem_d;
    logic [15:0] per_q, per_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            per_q <= '0;
        end else begin
            rem_q <= rem_d;
            per_q <= per_d;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = ^{burst_num, burst_period};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hold_d  = hold_q;
`ifdef TRIG_BURST_EN
        rem_d   = rem_q;
        per_d   = per_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arm && fall) begin
                    state_d = FIRE;
                    // Configuration is frozen for the whole sequence.
                    hold_d  = holdoff;
`ifdef TRIG_BURST_EN
                    rem_d   = burst_num;
                    per_d   = burst_period;
`endif
                end
            end
            FIRE: begin
`ifdef TRIG_BURST_EN
                if (rem_q != 8'd0) begin
                    if (per_q <= 16'd1) begin
                        // Back-to-back pulses: no GAP cycles fit.
                        state_d = FIRE;
                        rem_d   = rem_q - 8'd1;
                    end else begin
                        // GAP lasts per_q-1 cycles so FIRE-to-FIRE is per_q.
                        state_d = GAP;
                        timer_d = per_q - 16'd2;
                    end
                end else
`endif
                if (hold_q != 16'd0) begin
                    state_d = HOLDOFF;
                    timer_d = hold_q - 16'd1;
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef TRIG_BURST_EN
            GAP: begin
                if (timer_q == 16'd0) begin
                    state_d = FIRE;
                    rem_d   = rem_q - 8'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            HOLDOFF: begin
                if (timer_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!arm) begin
            state_d = IDLE;
        end
    end

    assign trigger = (state_q == FIRE);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            missed     <= 1'b0;
            trig_count <= '0;
        end else begin
            // A new miss wins over a simultaneous clear.
            if (fall && (state_q != IDLE)) begin
                missed <= 1'b1;
            end else if (clr_status) begin
                missed <= 1'b0;
            end
            // A clear coinciding with a pulse keeps that pulse counted.
            if (clr_status) begin
                trig_count <= trigger ? CNT_W'(1) : '0;
            end else if (trigger && (trig_count != '1)) begin
                trig_count <= trig_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count on trig_in (legal 2..4).
REQ-002 The module SHALL have parameter CNT_W, default 16: width of trig_count.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port trig_in, input, 1: asynchronous external trigger; its active event is the falling edge.
REQ-006 Port arm, input, 1: level; 1 = accept edges, 0 = ignore edges and abort any activity.
REQ-007 Port filter_len, input, 4: glitch filter length in clocks.
REQ-008 Port holdoff, input, 16: dead time in clocks after the last emitted pulse.
REQ-009 Port burst_num, input, 8: extra pulses per accepted edge (burst build only).
REQ-010 Port burst_period, input, 16: clocks between burst pulses (burst build only).
REQ-011 Port clr_status, input, 1: one-cycle clear of missed and trig_count.
REQ-012 Port trigger, output, 1: one-clock active-high start pulse to the pulse_generation trigger input.
REQ-013 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 Port missed, output, 1: sticky flag; a filtered falling edge arrived while busy.
REQ-015 Port trig_count, output, CNT_W: count of emitted trigger pulses, saturating.

Function
REQ-016 trig_in SHALL pass through SYNC_STAGES flops to produce trig_s.
REQ-017 The filtered level trig_f SHALL take the value of trig_s only after trig_s has differed from trig_f for filter_len+1 consecutive clocks; filter_len=0 makes trig_f a one-clock-delayed copy of trig_s.
REQ-018 A falling edge (fall) SHALL be trig_f_prev=1 and trig_f=0, registered once.
REQ-019 The FSM SHALL have states IDLE, FIRE, GAP and HOLDOFF.
REQ-020 IDLE: arm=1 and fall=1 -> FIRE; on this transition holdoff, burst_num and burst_period SHALL be latched, and later input changes SHALL be ignored until the next IDLE.
REQ-021 FIRE SHALL last one clock with trigger=1 and trig_count incremented, saturating at all-ones.
REQ-022 FIRE SHALL go to GAP if burst pulses remain; else to HOLDOFF if latched holdoff>0; else to IDLE.
REQ-023 GAP SHALL wait so that consecutive trigger pulses are exactly max(burst_period,1) clocks apart, then go to FIRE and decrement the remaining-burst count.
REQ-024 HOLDOFF SHALL remain for exactly latched holdoff clocks, then go to IDLE.
REQ-025 The latency from the trig_in falling edge to trigger high SHALL be SYNC_STAGES+filter_len+2 clocks, for a clean edge.
REQ-026 A fall while state≠IDLE SHALL set missed and SHALL NOT queue an event.
REQ-027 arm=0 in any state SHALL force IDLE on the next clock, with no further trigger pulses.
REQ-028 clr_status SHALL clear missed and trig_count; clr_status coinciding with FIRE SHALL leave trig_count=1.
REQ-029 clr_status coinciding with a missed-setting fall SHALL leave missed=1.

Reset
REQ-030 rst SHALL set state=IDLE, trigger=0, busy=0, missed=0 and trig_count=0.
REQ-031 rst SHALL preset all synchronizer and filter flops and trig_f_prev to 1 (trigger idle-high), so that release never produces a spurious fall.
REQ-032 rst asserted mid-burst or mid-holdoff SHALL abort immediately, with no trigger pulse in the cycle after the reset cycle.

Configuration
REQ-033 Macro TRIG_BURST_EN defined: the GAP state, burst_num and burst_period SHALL be functional.
REQ-034 Macro TRIG_BURST_EN undefined: GAP logic SHALL be removed, burst_num and burst_period SHALL be ignored, and exactly one pulse SHALL be emitted per accepted edge.

Structure
REQ-035 Package trig_pkg SHALL hold the FSM state enum, the SYNC_STAGES and CNT_W defaults, and the reset level constant.
REQ-036 Sub-module trig_glitch_filter SHALL contain the synchronizer, filter and edge detect (REQ-016..018).

Verification
REQ-037 filter_len=3, holdoff=0, single clean fall -> one trigger pulse exactly 7 clocks after the edge (SYNC_STAGES=2), trig_count=1.
REQ-038 filter_len=3, 2-clock low glitch on trig_in -> no trigger, trig_count stays 0.
REQ-039 holdoff=100, second fall 50 clocks after the first -> no second pulse, missed=1, busy low 100 clocks after the first pulse.
REQ-040 TRIG_BURST_EN defined, burst_num=3, burst_period=10 -> 4 pulses at offsets 0/10/20/30; arm dropped after the 2nd pulse -> only 2 pulses, and busy=0 one clock later.
REQ-041 trig_count=0xFFFF plus one more edge -> stays 0xFFFF; clr_status -> 0 next clock.
REQ-042 rst asserted in HOLDOFF and released with trig_in low -> no trigger, all outputs at reset values.
